// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the 16-bit MIPS fetch stage and its pipeline registers.
// No logic; imported by every fetch-stage file.
package fetch_stage_pkg;

    localparam int unsigned    DATA_W    = 16;
    localparam int unsigned    OPC_HI    = 15;
    localparam int unsigned    OPC_LO    = 12;
    localparam logic [3:0]     HALT_OPC  = 4'hF;
    localparam logic [15:0]    NOP_WORD  = 16'h0000;
    localparam logic [15:0]    PC_RESET  = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc_inc;
        logic              valid;
    } ifid_t;

    function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and IF/ID outputs.
// master = fetch stage, slave = surrounding core / memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic              stall;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic [DATA_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic [DATA_W-1:0] id_instr;
    logic [DATA_W-1:0] id_pc_inc;
    logic              id_valid;
    logic              halted;
    logic [DATA_W-1:0] fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_instr,
        output imem_addr, id_instr, id_pc_inc, id_valid, halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_instr,
        input  imem_addr, id_instr, id_pc_inc, id_valid, halted, fetch_count
    );

endinterface

// File: rtl/fetch_stage_add.sv
// Generic two's-complement adder with carry-in, carry-out and signed overflow.
// Latency: combinational. Backpressure: none.
module fetch_stage_add #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];
    assign ovf  = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register (instr, pc_inc, valid); flush inserts a bubble, hold freezes contents.
// Latency: 1 cycle. Backpressure: hold from the hazard unit; flush beats hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP = NOP_WORD
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t r_q;
    ifid_t r_d;

    // A bubble keeps the stale pc_inc: it is meaningless while valid is low.
    always_comb begin
        r_d = r_q;
        if (flush) begin
            r_d.instr = NOP;
            r_d.valid = 1'b0;
        end else if (!hold) begin
            r_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q.instr  <= NOP;
            r_q.pc_inc <= '0;
            r_q.valid  <= 1'b0;
        end else begin
            r_q <= r_d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads imem combinationally, loads IF/ID, stops on HALT opcode.
// Latency: word at PC appears on id_* after one edge. Backpressure: stall holds everything; redirect overrides.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       WIDTH       = DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC    = PC_RESET,
    parameter logic [DATA_W-1:0] NOP_INSTR   = NOP_WORD,
    parameter logic [3:0]        HALT_OPCODE = HALT_OPC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    localparam logic [WIDTH-1:0]  PC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  pc_plus1;
    logic              add_cout_unused;
    logic              add_ovf_unused;
    logic              ifid_hold;
    logic              ifid_flush;
    ifid_t             ifid_d;
    ifid_t             ifid_q;

    fetch_stage_add #(.W(WIDTH)) u_pc_add (
        .a    (pc_q),
        .b    (PC_ONE),
        .cin  (1'b0),
        .sum  (pc_plus1),
        .cout (add_cout_unused),
        .ovf  (add_ovf_unused)
    );

    // Priority: redirect > stall > halt bubble > fetch (halt detect inside fetch).
    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        ifid_hold     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_d.instr  = bus.imem_instr;
        ifid_d.pc_inc = pc_plus1;
        ifid_d.valid  = 1'b1;
        if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            state_d    = ST_RUN;
            ifid_flush = 1'b1;
        end else if (bus.stall) begin
            ifid_hold  = 1'b1;
        end else if (state_q == ST_HALT) begin
            ifid_flush = 1'b1;
        end else begin
            // The HALT word itself is delivered downstream; only the PC freezes.
            if (opcode_of(bus.imem_instr) == HALT_OPCODE) begin
                state_d = ST_HALT;
            end else begin
                pc_d    = pc_plus1;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
        .clk   (clk),
        .rst_n (reset),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.id_instr    = ifid_q.instr;
    assign bus.id_pc_inc   = ifid_q.pc_inc;
    assign bus.id_valid    = ifid_q.valid;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against an instruction-level reference model.
module tb_fetch_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] mem [0:65535];

    // Reference model of the architectural fetch state.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pcinc;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_cnt;

    fetch_stage_if bus_if ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    assign bus_if.imem_instr = mem[bus_if.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_instr  = 16'h0000;
        m_pcinc  = 16'h0000;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 16'h0000;
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [15:0] rpc);
        logic [15:0] w;
        w = mem[m_pc];
        if (rd) begin
            m_pc     = rpc;
            m_valid  = 1'b0;
            m_instr  = 16'h0000;
            m_halted = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (m_halted) begin
            m_valid = 1'b0;
            m_instr = 16'h0000;
        end else begin
            m_instr = w;
            m_pcinc = 16'(m_pc + 16'd1);
            m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = 16'(m_cnt + 16'd1);
            if (w[15:12] == 4'hF) m_halted = 1'b1;
            else                  m_pc = 16'(m_pc + 16'd1);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"},   bus_if.imem_addr,   m_pc);
        chk({tag, ".id_instr"},    bus_if.id_instr,    m_instr);
        chk({tag, ".id_valid"},    bus_if.id_valid,    m_valid);
        chk({tag, ".halted"},      bus_if.halted,      m_halted);
        chk({tag, ".fetch_count"}, bus_if.fetch_count, m_cnt);
        if (m_valid) chk({tag, ".id_pc_inc"}, bus_if.id_pc_inc, m_pcinc);
    endtask

    task automatic step(input string tag, input logic st, input logic rd, input logic [15:0] rpc);
        bus_if.stall       = st;
        bus_if.redirect    = rd;
        bus_if.redirect_pc = rpc;
        model_edge(st, rd, rpc);
        @(posedge clk);
        #1;
        check_all(tag);
        bus_if.stall    = 1'b0;
        bus_if.redirect = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom_range(0, 16'hEFFF));
    endtask

    initial begin
        logic [15:0] saved_cnt;
        logic [15:0] saved_instr;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus_if.stall       = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 16'h0000;
        fill_mem();
        mem[0] = 16'h1234;
        mem[1] = 16'h2345;
        model_reset();

        // Reset state
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Two sequential fetches
        step("t1_e1", 1'b0, 1'b0, 16'h0);
        chk("t1_e1_instr",  bus_if.id_instr,  16'h1234);
        chk("t1_e1_pcinc",  bus_if.id_pc_inc, 16'h0001);
        chk("t1_e1_valid",  bus_if.id_valid,  1'b1);
        step("t1_e2", 1'b0, 1'b0, 16'h0);
        chk("t1_e2_instr",  bus_if.id_instr,  16'h2345);
        chk("t1_e2_pcinc",  bus_if.id_pc_inc, 16'h0002);
        chk("t1_e2_pc",     bus_if.imem_addr, 16'h0002);

        // Stall at pc=5 for three cycles
        for (int i = 0; i < 3; i++) step("t2_run", 1'b0, 1'b0, 16'h0);
        chk("t2_pc5", bus_if.imem_addr, 16'h0005);
        saved_cnt   = m_cnt;
        saved_instr = m_instr;
        for (int i = 0; i < 3; i++) begin
            step("t2_stall", 1'b1, 1'b0, 16'h0);
            chk("t2_stall_pc",    bus_if.imem_addr,   16'h0005);
            chk("t2_stall_cnt",   bus_if.fetch_count, saved_cnt);
            chk("t2_stall_instr", bus_if.id_instr,    saved_instr);
        end
        step("t2_resume", 1'b0, 1'b0, 16'h0);
        chk("t2_resume_instr", bus_if.id_instr, mem[5]);

        // Redirect beats a simultaneous stall
        step("t3_redir", 1'b1, 1'b1, 16'h0040);
        chk("t3_pc",    bus_if.imem_addr, 16'h0040);
        chk("t3_valid", bus_if.id_valid,  1'b0);
        chk("t3_instr", bus_if.id_instr,  16'h0000);
        step("t3_fetch", 1'b0, 1'b0, 16'h0);
        chk("t3_fetch_instr", bus_if.id_instr, mem[16'h0040]);

        // HALT opcode, bubbles while halted, redirect leaves HALT
        mem[9] = 16'hF000;
        step("t4_redir9", 1'b0, 1'b1, 16'h0009);
        step("t4_halt", 1'b0, 1'b0, 16'h0);
        chk("t4_halt_instr",  bus_if.id_instr,  16'hF000);
        chk("t4_halt_valid",  bus_if.id_valid,  1'b1);
        chk("t4_halted",      bus_if.halted,    1'b1);
        chk("t4_halt_pc",     bus_if.imem_addr, 16'h0009);
        for (int i = 0; i < 3; i++) begin
            step("t4_halted", 1'b0, 1'b0, 16'h0);
            chk("t4_bubble_valid", bus_if.id_valid,  1'b0);
            chk("t4_bubble_pc",    bus_if.imem_addr, 16'h0009);
        end
        step("t4_exit", 1'b0, 1'b1, 16'h0003);
        chk("t4_exit_halted", bus_if.halted, 1'b0);
        step("t4_fetch3", 1'b0, 1'b0, 16'h0);
        chk("t4_fetch3_instr", bus_if.id_instr, mem[3]);

        // PC wrap at 16'hFFFF
        mem[16'hFFFF] = 16'h1111;
        step("t5_redir", 1'b0, 1'b1, 16'hFFFF);
        step("t5_wrap", 1'b0, 1'b0, 16'h0);
        chk("t5_instr", bus_if.id_instr,  16'h1111);
        chk("t5_pcinc", bus_if.id_pc_inc, 16'h0000);
        chk("t5_pc",    bus_if.imem_addr, 16'h0000);

        // Randomized traffic with HALT words sprinkled in a small region
        for (int i = 0; i < 8; i++) mem[16'($urandom_range(16'h80, 16'hFF))] = 16'($urandom_range(16'hF000, 16'hFFFF));
        step("rnd_start", 1'b0, 1'b1, 16'h0080);
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 16'($urandom_range(16'h80, 16'hFF)));
        end

        // Asynchronous reset between edges while stalled
        bus_if.stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t6_async_rst");
        chk("t6_rst_pc", bus_if.imem_addr, 16'h0000);
        #1;
        reset = 1'b1;
        bus_if.stall = 1'b0;

        // fetch_count saturation
        fill_mem();
        for (int i = 0; i < 65536; i++) step("sat", 1'b0, 1'b0, 16'h0);
        chk("t6_sat_cnt", bus_if.fetch_count, 16'hFFFF);

        // Reset again while running
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst2");
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
